overlay_screen_renderer: RTL and testbench
==========================================

Name: overlay_screen_renderer

Overview:
- Parametrised, animated end-of-game and title overlay renderer. It is the successor to the static logo+icon overlay.
- Banner and icon slide in vertically, blink a programmable number of times, then hold. A BCD score readout is drawn below them.
- Image and font ROMs stay external. The block drives their coordinates and composites the returned pixels.
- Sits between the VGA timing/pixel counter and the screen compositor. One instance per overlay screen.

Parameters:
- BANNER_X, 192, banner left edge (px)
- BANNER_Y, 224, banner final top edge (px); must be >= SLIDE_START
- BANNER_W, 256, banner width
- BANNER_H, 32, banner height
- ICON_W, 32, icon width; icon sits at x = BANNER_X-ICON_W, same top as banner
- ICON_H, 32, icon height
- SCORE_W, 10, score input width
- DIGITS, 4, decimal digits shown; must be >= ceil(SCORE_W*log10(2))
- DIGIT_W, 8, glyph width
- DIGIT_H, 16, glyph height
- SCORE_X, 288, score field left edge
- SCORE_Y, 272, score field top edge
- SLIDE_START, 224, initial vertical offset (banner starts at BANNER_Y-SLIDE_START)
- SLIDE_STEP, 8, offset decrement per frame
- BLINK_FRAMES, 16, frames per blink half-period
- BLINK_TOGGLES, 6, visibility toggles before HOLD
- BG_RGB, 24'h000000, background colour
- DIGIT_RGB, 24'hFFFFFF, glyph foreground colour

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- x, in, 10, current pixel column
- y, in, 10, current pixel row
- frame_start, in, 1, one-cycle pulse at start of vertical blank
- active, in, 1, overlay screen selected
- score, in, SCORE_W, binary score
- banner_img_x, out, 10, banner ROM column (comb.)
- banner_img_y, out, 10, banner ROM row (comb.)
- banner_rgba, in, 25, {R,G,B,A} from banner ROM
- icon_img_x, out, 10, icon ROM column (comb.)
- icon_img_y, out, 10, icon ROM row (comb.)
- icon_rgba, in, 25, {R,G,B,A} from icon ROM
- glyph_code, out, 4, digit 0-9 for font ROM (comb.)
- glyph_x, out, 4, glyph column (comb.)
- glyph_y, out, 5, glyph row (comb.)
- glyph_bit, in, 1, font pixel
- R, out, 8, output red
- G, out, 8, output green
- B, out, 8, output blue
- A, out, 1, output alpha/valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: R=G=B=0, A=0, state=IDLE, offset=SLIDE_START, visible=1, blink counters 0, digits_valid=0.
- States: IDLE, SLIDE, BLINK, HOLD. Every state returns to IDLE on the next cycle when active=0, with offset, visible, counters and digits_valid all reloaded to reset values.
- IDLE -> SLIDE: on the first cycle with active=1. In the same cycle, score is latched and bin2bcd conversion starts.
- SLIDE, on each frame_start:
  - if offset <= SLIDE_STEP: offset<=0 and go to BLINK;
  - else offset <= offset - SLIDE_STEP.
- BLINK, on each frame_start: increment the frame counter.
  - At BLINK_FRAMES-1: toggle visible, clear the counter, increment the toggle count.
  - When the toggle count reaches BLINK_TOGGLES: go to HOLD and force visible=1.
- HOLD: static; stays until active=0.
- Geometry updates: offset and visible change only on frame_start, so no tearing mid-frame.
- Banner top = BANNER_Y-offset; icon top is the same.
- Hit tests use half-open ranges [start, start+size) in 10-bit unsigned compare.
- Image coordinates = x/y minus the region origin, truncated to 10 bits. They are driven regardless of hit.
- Score digits:
  - bin2bcd needs SCORE_W cycles; digits_valid rises after that.
  - score changes after the latch are ignored until the next IDLE->SLIDE.
  - Digit index 0 is the most significant, at SCORE_X.
  - Leading zeros are blanked, except the least significant digit, so score 0 shows "0".
  - Score field is drawn only in BLINK/HOLD with digits_valid=1.
  - A blanked digit reads glyph_bit as don't-care and outputs BG_RGB.
- Pixel priority:
  - banner (visible, hit, A=1);
  - then icon (visible, hit, A=1);
  - then glyph (glyph_bit=1 gives DIGIT_RGB);
  - otherwise BG_RGB with A=1.
- A banner or icon pixel with A=0 falls through to the next priority.
- Latency: ROM inputs are treated as combinational. {R,G,B,A} is registered, one cycle after x/y.
- IDLE output: RGB=0, A=0 (transparent).
- Simultaneous events: active falling on a frame_start cycle resolves to IDLE; the animation step is discarded.

Decomposition:
- Shared package overlay_pkg:
  - SCREEN_X=640, SCREEN_Y=480;
  - RGBA_W=25;
  - state enum {IDLE, SLIDE, BLINK, HOLD};
  - colour constants.
- One sub-module, bin2bcd_seq:
  - sequential double-dabble, parametrised by SCORE_W and DIGITS;
  - ports: clk, rst, start, bin, bcd, done.

Test Plan:
- rst held 2 cycles -> R=G=B=0, A=0; active=1 then 29 frame_starts with defaults -> BLINK reached on the 28th (offset 224->0 in steps of 8).
- During SLIDE, offset=112, at x=200, y=112 -> banner_img_x=8, banner_img_y=0; banner_rgba returned appears on R/G/B one cycle later.
- BLINK, frames counted from BLINK entry:
  - banner hidden during frames 16-31;
  - visible again at 32;
  - HOLD entered after 96 frames, with visible=1.
- score=305 latched -> after 10 cycles digits 0,3,0,5:
  - digit 0 blanked to BG;
  - glyph_code=3 at x=296..303;
  - score=0 shows only the rightmost "0".
- Overlap: banner_rgba A=0 over a score glyph pixel (glyph_bit=1) -> output DIGIT_RGB.
- active dropped coincident with frame_start mid-BLINK -> next cycle IDLE, A=0; active reasserted -> banner restarts at y=0.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared definitions for the animated overlay screen renderer: screen size,
// RGBA word width, animation states, colour constants and a BCD helper.
package overlay_pkg;

  localparam int SCREEN_X = 640;
  localparam int SCREEN_Y = 480;
  localparam int RGBA_W   = 25;

  localparam logic [23:0] COLOUR_BLACK = 24'h000000;
  localparam logic [23:0] COLOUR_WHITE = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    BLINK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] dabbleAdjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/overlay_screen_renderer_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per cycle,
// so a conversion takes SCORE_W cycles after the start pulse.
module bin2bcd_seq
  import overlay_pkg::*;
#(
  parameter int SCORE_W = 10,
  parameter int DIGITS  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [SCORE_W-1:0]    i_bin,
  output logic [DIGITS*4-1:0]   o_bcd,
  output logic                  o_done
);

  localparam int CW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0]  r_bin;
  logic [DIGITS*4-1:0] r_bcd;
  logic [DIGITS*4-1:0] w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_adj[i*4 +: 4] = dabbleAdjust(r_bcd[i*4 +: 4]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_bcd <= (w_adj << 1) | {{(DIGITS*4-1){1'b0}}, r_bin[SCORE_W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(SCORE_W - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/overlay_screen_renderer.sv
// Animated title/end-of-game overlay: banner and icon slide in, blink, then hold,
// with a BCD score readout below; composites external ROM pixels into registered RGBA.
module overlay_screen_renderer
  import overlay_pkg::*;
#(
  parameter int          BANNER_X      = 192,
  parameter int          BANNER_Y      = 224,
  parameter int          BANNER_W      = 256,
  parameter int          BANNER_H      = 32,
  parameter int          ICON_W        = 32,
  parameter int          ICON_H        = 32,
  parameter int          SCORE_W       = 10,
  parameter int          DIGITS        = 4,
  parameter int          DIGIT_W       = 8,
  parameter int          DIGIT_H       = 16,
  parameter int          SCORE_X       = 288,
  parameter int          SCORE_Y       = 272,
  parameter int          SLIDE_START   = 224,
  parameter int          SLIDE_STEP    = 8,
  parameter int          BLINK_FRAMES  = 16,
  parameter int          BLINK_TOGGLES = 6,
  parameter logic [23:0] BG_RGB        = COLOUR_BLACK,
  parameter logic [23:0] DIGIT_RGB     = COLOUR_WHITE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [9:0]         i_x,
  input  logic [9:0]         i_y,
  input  logic               i_frame_start,
  input  logic               i_active,
  input  logic [SCORE_W-1:0] i_score,
  output logic [9:0]         o_banner_img_x,
  output logic [9:0]         o_banner_img_y,
  input  logic [RGBA_W-1:0]  i_banner_rgba,
  output logic [9:0]         o_icon_img_x,
  output logic [9:0]         o_icon_img_y,
  input  logic [RGBA_W-1:0]  i_icon_rgba,
  output logic [3:0]         o_glyph_code,
  output logic [3:0]         o_glyph_x,
  output logic [4:0]         o_glyph_y,
  input  logic               i_glyph_bit,
  output logic [7:0]         o_r,
  output logic [7:0]         o_g,
  output logic [7:0]         o_b,
  output logic               o_a
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  localparam logic [9:0] BANNER_X0 = 10'(BANNER_X);
  localparam logic [9:0] BANNER_XE = 10'(BANNER_X + BANNER_W);
  localparam logic [9:0] ICON_X0   = 10'(BANNER_X - ICON_W);
  localparam logic [9:0] ICON_XE   = 10'(BANNER_X);
  localparam logic [9:0] SCORE_X0  = 10'(SCORE_X);
  localparam logic [9:0] SCORE_XE  = 10'(SCORE_X + DIGITS * DIGIT_W);
  localparam logic [9:0] SCORE_Y0  = 10'(SCORE_Y);
  localparam logic [9:0] SCORE_YE  = 10'(SCORE_Y + DIGIT_H);

  state_t      r_state, w_stateNext;
  logic [9:0]  r_offset, w_offsetNext;
  logic        r_visible, w_visibleNext;
  logic [FW-1:0] r_frameCnt, w_frameCntNext;
  logic [TW-1:0] r_toggleCnt, w_toggleCntNext;
  logic [TW-1:0] w_toggleInc;

  logic [7:0]  r_r, r_g, r_b;
  logic        r_a;
  logic [23:0] w_rgbNext;
  logic        w_aNext;

  logic                w_convStart;
  logic                w_convRst;
  logic [DIGITS*4-1:0] w_bcd;
  logic                w_digitsValid;

  logic [9:0]  w_bannerTop, w_bannerBot, w_iconBot;
  logic        w_bannerHit, w_iconHit, w_scoreHit, w_scoreShown;
  logic [9:0]  w_relX;
  logic [DIGITS-1:0] w_blank;
  logic        w_lead;
  logic [3:0]  w_glyphCode, w_glyphX;
  logic        w_digitBlank;

  // Dropping active flushes the converter so digits are invalid until the next latch.
  assign w_convStart = (r_state == IDLE) && i_active;
  assign w_convRst   = i_rst | ~i_active;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (w_convRst),
    .i_start (w_convStart),
    .i_bin   (i_score),
    .o_bcd   (w_bcd),
    .o_done  (w_digitsValid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_offset    <= 10'(SLIDE_START);
      r_visible   <= 1'b1;
      r_frameCnt  <= '0;
      r_toggleCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_offset    <= w_offsetNext;
      r_visible   <= w_visibleNext;
      r_frameCnt  <= w_frameCntNext;
      r_toggleCnt <= w_toggleCntNext;
    end
  end

  assign w_toggleInc = r_toggleCnt + 1'b1;

  // Animation only advances on frame_start so geometry never changes mid-frame.
  always_comb begin
    w_stateNext     = r_state;
    w_offsetNext    = r_offset;
    w_visibleNext   = r_visible;
    w_frameCntNext  = r_frameCnt;
    w_toggleCntNext = r_toggleCnt;
    if (!i_active) begin
      w_stateNext     = IDLE;
      w_offsetNext    = 10'(SLIDE_START);
      w_visibleNext   = 1'b1;
      w_frameCntNext  = '0;
      w_toggleCntNext = '0;
    end else begin
      case (r_state)
        IDLE: w_stateNext = SLIDE;
        SLIDE: begin
          if (i_frame_start) begin
            if (r_offset <= 10'(SLIDE_STEP)) begin
              w_offsetNext = '0;
              w_stateNext  = BLINK;
            end else begin
              w_offsetNext = r_offset - 10'(SLIDE_STEP);
            end
          end
        end
        BLINK: begin
          if (i_frame_start) begin
            if (r_frameCnt == FW'(BLINK_FRAMES - 1)) begin
              w_visibleNext   = ~r_visible;
              w_frameCntNext  = '0;
              w_toggleCntNext = w_toggleInc;
              if (w_toggleInc == TW'(BLINK_TOGGLES)) begin
                w_stateNext   = HOLD;
                w_visibleNext = 1'b1;
              end
            end else begin
              w_frameCntNext = r_frameCnt + 1'b1;
            end
          end
        end
        HOLD: w_stateNext = HOLD;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign w_bannerTop = 10'(BANNER_Y) - r_offset;
  assign w_bannerBot = w_bannerTop + 10'(BANNER_H);
  assign w_iconBot   = w_bannerTop + 10'(ICON_H);

  assign w_bannerHit = (i_x >= BANNER_X0) && (i_x < BANNER_XE) &&
                       (i_y >= w_bannerTop) && (i_y < w_bannerBot);
  assign w_iconHit   = (i_x >= ICON_X0) && (i_x < ICON_XE) &&
                       (i_y >= w_bannerTop) && (i_y < w_iconBot);
  assign w_scoreHit  = (i_x >= SCORE_X0) && (i_x < SCORE_XE) &&
                       (i_y >= SCORE_Y0) && (i_y < SCORE_YE);
  assign w_scoreShown = ((r_state == BLINK) || (r_state == HOLD)) && w_digitsValid;

  assign o_banner_img_x = i_x - BANNER_X0;
  assign o_banner_img_y = i_y - w_bannerTop;
  assign o_icon_img_x   = i_x - ICON_X0;
  assign o_icon_img_y   = i_y - w_bannerTop;

  // Leading zeros are blanked, but the least significant digit always shows.
  always_comb begin
    w_lead  = 1'b1;
    w_blank = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_lead && (i != DIGITS - 1) && (w_bcd[(DIGITS-1-i)*4 +: 4] == 4'd0)) begin
        w_blank[i] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  assign w_relX = i_x - SCORE_X0;

  always_comb begin
    w_glyphCode  = '0;
    w_glyphX     = '0;
    w_digitBlank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((w_relX >= 10'(i * DIGIT_W)) && (w_relX < 10'((i + 1) * DIGIT_W))) begin
        w_glyphCode  = w_bcd[(DIGITS-1-i)*4 +: 4];
        w_glyphX     = 4'(w_relX - 10'(i * DIGIT_W));
        w_digitBlank = w_blank[i];
      end
    end
  end

  assign o_glyph_code = w_glyphCode;
  assign o_glyph_x    = w_glyphX;
  assign o_glyph_y    = 5'(i_y - SCORE_Y0);

  // Gating on i_active too makes the output go transparent on the same edge as the state.
  always_comb begin
    w_rgbNext = BG_RGB;
    w_aNext   = 1'b1;
    if ((r_state == IDLE) || !i_active) begin
      w_rgbNext = 24'h000000;
      w_aNext   = 1'b0;
    end else if (r_visible && w_bannerHit && i_banner_rgba[0]) begin
      w_rgbNext = i_banner_rgba[24:1];
    end else if (r_visible && w_iconHit && i_icon_rgba[0]) begin
      w_rgbNext = i_icon_rgba[24:1];
    end else if (w_scoreShown && w_scoreHit && !w_digitBlank && i_glyph_bit) begin
      w_rgbNext = DIGIT_RGB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
      r_a <= 1'b0;
    end else begin
      r_r <= w_rgbNext[23:16];
      r_g <= w_rgbNext[15:8];
      r_b <= w_rgbNext[7:0];
      r_a <= w_aNext;
    end
  end

  assign o_r = r_r;
  assign o_g = r_g;
  assign o_b = r_b;
  assign o_a = r_a;

endmodule

// File: tb/tb_overlay_screen_renderer.sv
// Directed bench for overlay_screen_renderer with default parameters: slide timing,
// ROM coordinates, blink/hold sequence, score digits and pixel priority.
module tb_overlay_screen_renderer;

  logic        clk;
  logic        rst;
  logic [9:0]  x, y;
  logic        frameStart;
  logic        active;
  logic [9:0]  score;
  logic [9:0]  bannerImgX, bannerImgY, iconImgX, iconImgY;
  logic [24:0] bannerRgba, iconRgba;
  logic [3:0]  glyphCode, glyphX;
  logic [4:0]  glyphY;
  logic        glyphBit;
  logic [7:0]  r, g, b;
  logic        a;

  int testsRun = 0;
  int testsFailed = 0;

  overlay_screen_renderer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_x            (x),
    .i_y            (y),
    .i_frame_start  (frameStart),
    .i_active       (active),
    .i_score        (score),
    .o_banner_img_x (bannerImgX),
    .o_banner_img_y (bannerImgY),
    .i_banner_rgba  (bannerRgba),
    .o_icon_img_x   (iconImgX),
    .o_icon_img_y   (iconImgY),
    .i_icon_rgba    (iconRgba),
    .o_glyph_code   (glyphCode),
    .o_glyph_x      (glyphX),
    .o_glyph_y      (glyphY),
    .i_glyph_bit    (glyphBit),
    .o_r            (r),
    .o_g            (g),
    .o_b            (b),
    .o_a            (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frameStart = 1'b1;
      tick(1);
      frameStart = 1'b0;
      tick(1);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py,
                               input logic [24:0] bRgba, input logic [24:0] iRgba,
                               input logic gBit);
    x = px;
    y = py;
    bannerRgba = bRgba;
    iconRgba = iRgba;
    glyphBit = gBit;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPixel(input string tag, input logic [23:0] expRgb, input logic expA);
    checkOutput({tag, "_rgb"}, {8'h0, r, g, b}, {8'h0, expRgb});
    checkOutput({tag, "_a"}, {31'h0, a}, {31'h0, expA});
  endtask

  initial begin
    rst = 1'b1;
    active = 1'b0;
    frameStart = 1'b0;
    score = 10'd0;
    x = '0;
    y = '0;
    bannerRgba = '0;
    iconRgba = '0;
    glyphBit = 1'b0;
    tick(2);
    checkPixel("reset", 24'h000000, 1'b0);
    rst = 1'b0;
    tick(1);
    checkPixel("idleInactive", 24'h000000, 1'b0);

    // Start: score 305 latched, later score change ignored.
    score = 10'd305;
    active = 1'b1;
    applyStimulus(10'd0, 10'd0, 25'h0, 25'h0, 1'b0);
    tick(1);
    checkPixel("idleEdge", 24'h000000, 1'b0);
    score = 10'd999;
    tick(1);
    checkPixel("slideBg", 24'h000000, 1'b1);

    // 14 frames: offset 112, banner top 112.
    frames(14);
    applyStimulus(10'd200, 10'd112, {24'h123456, 1'b1}, {24'h654321, 1'b1}, 1'b0);
    checkOutput("bannerImgX", {22'h0, bannerImgX}, 32'd8);
    checkOutput("bannerImgY", {22'h0, bannerImgY}, 32'd0);
    checkOutput("iconImgX", {22'h0, iconImgX}, 32'd40);
    tick(1);
    checkPixel("bannerPix", 24'h123456, 1'b1);
    applyStimulus(10'd170, 10'd112, {24'h123456, 1'b1}, {24'h654321, 1'b1}, 1'b0);
    tick(1);
    checkPixel("iconPix", 24'h654321, 1'b1);
    applyStimulus(10'd170, 10'd112, {24'h123456, 1'b1}, {24'h654321, 1'b0}, 1'b0);
    tick(1);
    checkPixel("iconTransparent", 24'h000000, 1'b1);
    applyStimulus(10'd200, 10'd111, {24'h123456, 1'b1}, 25'h0, 1'b0);
    checkOutput("bannerImgYWrap", {22'h0, bannerImgY}, 32'h3FF);
    tick(1);
    checkPixel("aboveBanner", 24'h000000, 1'b1);
    applyStimulus(10'd200, 10'd112, {24'h123456, 1'b0}, 25'h0, 1'b0);
    tick(1);
    checkPixel("bannerTransparent", 24'h000000, 1'b1);

    // 27 frames total: offset 8; 28th reaches BLINK with offset 0.
    frames(13);
    applyStimulus(10'd200, 10'd216, 25'h0, 25'h0, 1'b0);
    checkOutput("offset8ImgY", {22'h0, bannerImgY}, 32'd0);
    applyStimulus(10'd300, 10'd280, 25'h0, 25'h0, 1'b1);
    tick(1);
    checkPixel("noScoreInSlide", 24'h000000, 1'b1);
    frames(1);
    applyStimulus(10'd200, 10'd224, 25'h0, 25'h0, 1'b0);
    checkOutput("offset0ImgY", {22'h0, bannerImgY}, 32'd0);

    // Score 305 -> blank,3,0,5.
    applyStimulus(10'd296, 10'd272, {24'hABCDEF, 1'b0}, 25'h0, 1'b1);
    checkOutput("code3Left", {28'h0, glyphCode}, 32'd3);
    checkOutput("glyphX0", {28'h0, glyphX}, 32'd0);
    checkOutput("glyphY0", {27'h0, glyphY}, 32'd0);
    tick(1);
    checkPixel("overlapGlyph", 24'hFFFFFF, 1'b1);
    applyStimulus(10'd303, 10'd287, 25'h0, 25'h0, 1'b1);
    checkOutput("code3Right", {28'h0, glyphCode}, 32'd3);
    checkOutput("glyphX7", {28'h0, glyphX}, 32'd7);
    checkOutput("glyphY15", {27'h0, glyphY}, 32'd15);
    applyStimulus(10'd288, 10'd280, 25'h0, 25'h0, 1'b1);
    checkOutput("code0Lead", {28'h0, glyphCode}, 32'd0);
    tick(1);
    checkPixel("blankLead", 24'h000000, 1'b1);
    applyStimulus(10'd304, 10'd280, 25'h0, 25'h0, 1'b1);
    checkOutput("code0Inner", {28'h0, glyphCode}, 32'd0);
    tick(1);
    checkPixel("innerZero", 24'hFFFFFF, 1'b1);
    applyStimulus(10'd312, 10'd280, 25'h0, 25'h0, 1'b1);
    checkOutput("code5", {28'h0, glyphCode}, 32'd5);
    applyStimulus(10'd300, 10'd280, 25'h0, 25'h0, 1'b0);
    tick(1);
    checkPixel("glyphOff", 24'h000000, 1'b1);
    applyStimulus(10'd320, 10'd280, 25'h0, 25'h0, 1'b1);
    tick(1);
    checkPixel("fieldEnd", 24'h000000, 1'b1);
    applyStimulus(10'd300, 10'd288, 25'h0, 25'h0, 1'b1);
    tick(1);
    checkPixel("fieldBottom", 24'h000000, 1'b1);

    // Blink sequence counted from BLINK entry.
    applyStimulus(10'd200, 10'd224, {24'h123456, 1'b1}, 25'h0, 1'b0);
    frames(15);
    tick(1);
    checkPixel("blink15Vis", 24'h123456, 1'b1);
    frames(1);
    tick(1);
    checkPixel("blink16Hid", 24'h000000, 1'b1);
    frames(16);
    tick(1);
    checkPixel("blink32Vis", 24'h123456, 1'b1);
    frames(48);
    tick(1);
    checkPixel("blink80Hid", 24'h000000, 1'b1);
    frames(15);
    tick(1);
    checkPixel("blink95Hid", 24'h000000, 1'b1);
    frames(1);
    tick(1);
    checkPixel("hold96Vis", 24'h123456, 1'b1);
    frames(20);
    tick(1);
    checkPixel("holdStatic", 24'h123456, 1'b1);

    // Drop active, restart with score 0.
    active = 1'b0;
    tick(1);
    checkPixel("dropIdle", 24'h000000, 1'b0);
    score = 10'd0;
    active = 1'b1;
    applyStimulus(10'd200, 10'd0, {24'h123456, 1'b1}, 25'h0, 1'b0);
    checkOutput("restartImgY", {22'h0, bannerImgY}, 32'd0);
    tick(2);
    checkPixel("restartTop", 24'h123456, 1'b1);
    frames(28);
    frames(20);
    applyStimulus(10'd312, 10'd272, {24'h123456, 1'b1}, 25'h0, 1'b1);
    checkOutput("zeroCode", {28'h0, glyphCode}, 32'd0);
    tick(1);
    checkPixel("scoreZero", 24'hFFFFFF, 1'b1);
    applyStimulus(10'd304, 10'd272, 25'h0, 25'h0, 1'b1);
    tick(1);
    checkPixel("zeroBlank2", 24'h000000, 1'b1);
    applyStimulus(10'd288, 10'd272, 25'h0, 25'h0, 1'b1);
    tick(1);
    checkPixel("zeroBlank0", 24'h000000, 1'b1);

    // Active falls on a frame_start mid-BLINK: step discarded, IDLE next.
    applyStimulus(10'd200, 10'd224, {24'h123456, 1'b1}, 25'h0, 1'b0);
    active = 1'b0;
    frameStart = 1'b1;
    tick(1);
    frameStart = 1'b0;
    checkPixel("dropOnFrame", 24'h000000, 1'b0);
    checkOutput("offsetReloaded", {22'h0, bannerImgY}, 32'd224);
    active = 1'b1;
    tick(1);
    checkPixel("reassertEdge", 24'h000000, 1'b0);
    tick(1);
    checkPixel("reassertOldRow", 24'h000000, 1'b1);
    applyStimulus(10'd200, 10'd0, {24'h123456, 1'b1}, 25'h0, 1'b0);
    tick(1);
    checkPixel("reassertTop", 24'h123456, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
